// File: rtl/bmc_soft_pipe.sv
// -----------------------------------------------------------------------------
// bmc_soft_pipe
//   Two-stage branch metric unit for the Viterbi decoder datapath. One received
//   codeword of N soft symbols is accepted per transfer. For each of the 2**N
//   expected codewords (hypotheses), the unit computes the summed soft distance.
//   It also reports the lowest-index hypothesis that holds the minimum metric.
//   Punctured symbols (erase[i]=1) contribute nothing to any metric.
//   With SOFT_W=1 and no erasures, the metrics equal Hamming distances.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input codeword valid
//   in_ready   input can be accepted this cycle (independent of in_valid)
//   rx_sym     N soft symbols, symbol i at [i*SOFT_W +: SOFT_W]
//   erase      per-symbol puncture flags
//   in_last    end-of-frame marker, travels with its codeword
//   out_valid  metrics valid
//   out_ready  downstream accepts metrics
//   metrics    H metrics, hypothesis h at [h*MW +: MW]
//   min_idx    lowest-index hypothesis with the minimum metric
//   out_last   in_last of the codeword now on the output
// -----------------------------------------------------------------------------
module bmc_soft_pipe #(
   parameter  int N      = 2,
   parameter  int SOFT_W = 3,
   localparam int MW     = $clog2(N*(2**SOFT_W-1)+1),
   localparam int H      = 2**N
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*SOFT_W-1:0]   rx_sym,
   input  logic [N-1:0]          erase,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [H*MW-1:0]       metrics,
   output logic [N-1:0]          min_idx,
   output logic                  out_last
);

   localparam logic [SOFT_W-1:0] SYM_MAX = '1;

   logic                          s1_v_q, s2_v_q;
   logic                          s1_adv, s2_adv;
   logic [N-1:0][SOFT_W-1:0]      d0_d, d1_d, d0_q, d1_q;
   logic                          s1_last_q;
   logic [H-1:0][MW-1:0]          sum_d, metrics_q;
   logic [MW-1:0]                 best_d;
   logic [N-1:0]                  min_idx_d, min_idx_q;
   logic                          out_last_q;

   // A stage may load when it is empty or when its contents move on this
   // cycle, so bubbles collapse and a full pipe shifts without loss.
   assign s2_adv   = !s2_v_q || out_ready;
   assign s1_adv   = !s1_v_q || s2_adv;
   assign in_ready = s1_adv;

   // Per-symbol distances to an expected '0' and an expected '1'.
   always_comb begin
      d0_d = '0;
      d1_d = '0;
      for (int i = 0; i < N; i++) begin
         if (!erase[i]) begin
            d0_d[i] = rx_sym[i*SOFT_W +: SOFT_W];
            d1_d[i] = SYM_MAX - rx_sym[i*SOFT_W +: SOFT_W];
         end
      end
   end

   // ---- stage 1: distances and frame marker ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         d0_q      <= '0;
         d1_q      <= '0;
         s1_last_q <= 1'b0;
      end else if (s1_adv) begin
         s1_v_q <= in_valid;
         if (in_valid) begin
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            s1_last_q <= in_last;
         end
      end
   end

   // Hypothesis sums; bit i of h selects the expected value of symbol i.
   always_comb begin
      sum_d = '0;
      for (int h = 0; h < H; h++) begin
         for (int i = 0; i < N; i++) begin
            if (((h >> i) & 1) != 0)
               sum_d[h] = sum_d[h] + MW'(d1_q[i]);
            else
               sum_d[h] = sum_d[h] + MW'(d0_q[i]);
         end
      end
   end

   // Strict less-than scan upward, so ties resolve to the lowest index.
   always_comb begin
      best_d    = sum_d[0];
      min_idx_d = '0;
      for (int h = 1; h < H; h++) begin
         if (sum_d[h] < best_d) begin
            best_d    = sum_d[h];
            min_idx_d = N'(h);
         end
      end
   end

   // ---- stage 2: metrics, minimum index and frame marker ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q     <= 1'b0;
         metrics_q  <= '0;
         min_idx_q  <= '0;
         out_last_q <= 1'b0;
      end else if (s2_adv) begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            metrics_q  <= sum_d;
            min_idx_q  <= min_idx_d;
            out_last_q <= s1_last_q;
         end
      end
   end

   assign out_valid = s2_v_q;
   assign metrics   = metrics_q;
   assign min_idx   = min_idx_q;
   assign out_last  = out_last_q;

endmodule
